// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer around a single 1-bit adder cell.
// Operands are captured on start, processed LSB first, result registered.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] s_sr;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             bit_s;
  logic             carry_nx;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] s_nx;

  assign bit_s    = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_nx = (a_sr[0] & b_sr[0])
                  | (a_sr[0] & carry)
                  | (b_sr[0] & carry);
  assign last     = (cnt == CW'(WIDTH - 1));
  assign accept   = (state == IDLE) && start;
  assign s_nx     = {bit_s, s_sr};

  // State register, frozen when ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last)  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered status decode so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (ena) begin
      busy <= (state_d == RUN);
      done <= (state_d == DONE);
    end
  end

  // Operand capture, serial add step, and result latch on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (ena) begin
      if (accept) begin
        a_sr  <= a;
        b_sr  <= sub ? ~b : b;
        carry <= sub;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        s_sr  <= s_nx[WIDTH-1:1];
        carry <= carry_nx;
        cnt   <= cnt + 1'b1;
        if (last) begin
          sum  <= s_nx;
          cout <= carry_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl.
// Each task drives one scenario and checks against hand-computed values.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int npass;
  int ntot;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept an operation, then wait (bounded) for done.
  task automatic do_op(
    input  logic [7:0] ia,
    input  logic [7:0] ib,
    input  logic       isub,
    output int         lat,
    output int         bb,
    output logic [7:0] s,
    output logic       c,
    output logic       d2
  );
    a = ia; b = ib; sub = isub; start = 1'b1;
    tick;
    start = 1'b0;
    bb = 0;
    if (busy !== 1'b1) bb++;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      lat++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) bb++;
    end
    if (busy !== 1'b0) bb++;
    s = sum;
    c = cout;
    tick;
    d2 = done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ena = 1'b1;
    start = 1'b1;
    sub = 1'b1;
    a = 8'hC3;
    b = 8'h7E;
    tick;
    tick;
    ntot++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else npass++;
    ntot++;
    if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done);
    else npass++;
    ntot++;
    if (sum !== 8'h00) $display("FAIL reset_sum got %h want 00", sum);
    else npass++;
    ntot++;
    if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout);
    else npass++;
    start = 1'b0;
    rst_n = 1'b1;
    tick;
    tick;
    ntot++;
    if ({busy, done, cout, sum} !== 11'd0)
      $display("FAIL post_reset got %b%b%b %h want all 0",
               busy, done, cout, sum);
    else npass++;
  endtask

  task automatic test_add;
    int lat, bb;
    logic [7:0] s;
    logic c, d2;
    do_op(8'h5A, 8'h33, 1'b0, lat, bb, s, c, d2);
    ntot++;
    if (lat !== 8) $display("FAIL add_latency got %0d want 8", lat);
    else npass++;
    ntot++;
    if (bb !== 0) $display("FAIL add_busy got %0d bad cycles want 0", bb);
    else npass++;
    ntot++;
    if (s !== 8'h8D) $display("FAIL add_sum got %h want 8d", s);
    else npass++;
    ntot++;
    if (c !== 1'b0) $display("FAIL add_cout got %b want 0", c);
    else npass++;
    ntot++;
    if (d2 !== 1'b0) $display("FAIL add_done_width got %b want 0", d2);
    else npass++;
  endtask

  task automatic test_overflow;
    int lat, bb;
    logic [7:0] s;
    logic c, d2;
    do_op(8'hFF, 8'h01, 1'b0, lat, bb, s, c, d2);
    ntot++;
    if ({c, s} !== 9'h100)
      $display("FAIL ovf_add got %b %h want 1 00", c, s);
    else npass++;
    do_op(8'h10, 8'h01, 1'b1, lat, bb, s, c, d2);
    ntot++;
    if ({c, s} !== 9'h10F)
      $display("FAIL sub_noborrow got %b %h want 1 0f", c, s);
    else npass++;
    do_op(8'h00, 8'h01, 1'b1, lat, bb, s, c, d2);
    ntot++;
    if ({c, s} !== 9'h0FF)
      $display("FAIL sub_borrow got %b %h want 0 ff", c, s);
    else npass++;
    ntot++;
    if (lat !== 8) $display("FAIL sub_latency got %0d want 8", lat);
    else npass++;
  endtask

  task automatic test_ignore;
    int lat;
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 1) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b1;
      end
      if (i == 3) begin
        a = 8'h00; b = 8'hA5; sub = 1'b0;
      end
      if (i == 5) begin
        start = 1'b0; sub = 1'b1;
      end
      tick;
      lat++;
      if (done === 1'b1) break;
    end
    ntot++;
    if (lat !== 8) $display("FAIL ign_latency got %0d want 8", lat);
    else npass++;
    ntot++;
    if ({cout, sum} !== 9'h046)
      $display("FAIL ign_sum got %b %h want 0 46", cout, sum);
    else npass++;
    tick;
    ntot++;
    if ({busy, done} !== 2'b00)
      $display("FAIL ign_after got %b%b want 00", busy, done);
    else npass++;
  endtask

  task automatic test_ena;
    int lat;
    int hold_bad;
    a = 8'h5A; b = 8'h33; sub = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 0;
    hold_bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      lat++;
    end
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      lat++;
      if (busy !== 1'b1 || done !== 1'b0) hold_bad++;
    end
    ena = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick;
      lat++;
      if (done === 1'b1) break;
    end
    ntot++;
    if (hold_bad !== 0)
      $display("FAIL ena_run_hold got %0d bad want 0", hold_bad);
    else npass++;
    ntot++;
    if (lat !== 11) $display("FAIL ena_latency got %0d want 11", lat);
    else npass++;
    ntot++;
    if ({cout, sum} !== 9'h08D)
      $display("FAIL ena_sum got %b %h want 0 8d", cout, sum);
    else npass++;
    ena = 1'b0;
    hold_bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (done !== 1'b1) hold_bad++;
    end
    ntot++;
    if (hold_bad !== 0)
      $display("FAIL ena_done_hold got %0d bad want 0", hold_bad);
    else npass++;
    ena = 1'b1;
    tick;
    ntot++;
    if (done !== 1'b0) $display("FAIL ena_done_clear got %b want 0", done);
    else npass++;
  endtask

  task automatic test_reset_mid;
    int lat, bb, seen;
    logic [7:0] s;
    logic c, d2;
    a = 8'hA0; b = 8'h0B; sub = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    ntot++;
    if ({busy, done, cout, sum} !== 11'd0)
      $display("FAIL mid_reset got %b%b%b %h want all 0",
               busy, done, cout, sum);
    else npass++;
    tick;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    ntot++;
    if (seen !== 0) $display("FAIL mid_no_done got %0d want 0", seen);
    else npass++;
    do_op(8'h12, 8'h34, 1'b0, lat, bb, s, c, d2);
    ntot++;
    if ({c, s} !== 9'h046 || lat !== 8)
      $display("FAIL mid_restart got %b %h lat %0d want 0 46 lat 8",
               c, s, lat);
    else npass++;
  endtask

  task automatic test_back_to_back;
    int lat;
    a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
    tick;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      lat++;
      if (done === 1'b1) break;
    end
    ntot++;
    if (lat !== 8 || sum !== 8'h03)
      $display("FAIL b2b_first got lat %0d sum %h want lat 8 sum 03",
               lat, sum);
    else npass++;
    a = 8'h80; b = 8'h80;
    tick;
    ntot++;
    if (busy !== 1'b0) $display("FAIL b2b_idle got %b want 0", busy);
    else npass++;
    tick;
    start = 1'b0;
    ntot++;
    if (busy !== 1'b1) $display("FAIL b2b_retrig got %b want 1", busy);
    else npass++;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      lat++;
      if (done === 1'b1) break;
    end
    ntot++;
    if ({cout, sum} !== 9'h100 || lat !== 8)
      $display("FAIL b2b_second got %b %h lat %0d want 1 00 lat 8",
               cout, sum, lat);
    else npass++;
  endtask

  initial begin
    npass = 0;
    ntot = 0;
    rst_n = 1'b0;
    ena = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    a = '0;
    b = '0;
    test_reset;
    test_add;
    test_overflow;
    test_ignore;
    test_ena;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
